// File: rtl/icache_controller_pkg.sv
// Shared types for the instruction cache control slice.
package icache_controller_pkg;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_FILL    = 2'd1,
    IC_INSTALL = 2'd2
  } icache_state_e;

  localparam int STAT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Advance on inc unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/icache_controller.sv
// Control FSM for the direct-mapped icache: hits in the request cycle,
// misses refill the line from L2 highest word first, then install it.
module icache_controller
  import icache_controller_pkg::*;
#(
  parameter int STAT_WIDTH = STAT_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_req_valid,
  output logic                  pipe_req_fulfilled,
  output logic                  l2_req_valid,
  input  logic                  l2_req_fulfilled,
  input  logic                  valid_block_match,
  input  logic                  counter_done,
  output logic                  load_mode,
  output logic                  perform_write,
  output logic                  clear_selected_valid_bit,
  output logic                  finish_new_line_install,
  output logic                  set_new_l2_block_address,
  output logic                  reset_counter,
  output logic                  decrement_counter,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
);

  icache_state_e state_q;
  icache_state_e state_d;
  // Marks that the request now being served in IDLE is the one that just refilled
  logic          refilled_q;
  logic          refilled_d;
  logic          hit_inc;
  logic          miss_inc;

  // Next-state and output decode; reset holds every output low
  always_comb begin
    state_d                  = state_q;
    refilled_d               = refilled_q;
    pipe_req_fulfilled       = 1'b0;
    l2_req_valid             = 1'b0;
    load_mode                = 1'b0;
    perform_write            = 1'b0;
    clear_selected_valid_bit = 1'b0;
    finish_new_line_install  = 1'b0;
    set_new_l2_block_address = 1'b0;
    reset_counter            = 1'b0;
    decrement_counter        = 1'b0;
    hit_inc                  = 1'b0;
    miss_inc                 = 1'b0;
    if (!reset) begin
      case (state_q)
        IC_IDLE: begin
          refilled_d = 1'b0;
          if (pipe_req_valid) begin
            if (valid_block_match) begin
              pipe_req_fulfilled = 1'b1;
              hit_inc            = !refilled_q;
            end else begin
              clear_selected_valid_bit = 1'b1;
              set_new_l2_block_address = 1'b1;
              reset_counter            = 1'b1;
              miss_inc                 = 1'b1;
              state_d                  = IC_FILL;
            end
          end
        end
        IC_FILL: begin
          load_mode    = 1'b1;
          l2_req_valid = 1'b1;
          if (l2_req_fulfilled) begin
            perform_write = 1'b1;
            if (counter_done) begin
              state_d = IC_INSTALL;
            end else begin
              decrement_counter = 1'b1;
            end
          end
        end
        IC_INSTALL: begin
          finish_new_line_install = 1'b1;
          refilled_d              = 1'b1;
          state_d                 = IC_IDLE;
        end
        default: begin
          state_d = IC_IDLE;
        end
      endcase
    end
  end

  // State register and refill marker
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IC_IDLE;
      refilled_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      refilled_q <= refilled_d;
    end
  end

  sat_counter #(.WIDTH(STAT_WIDTH)) u_hit_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(STAT_WIDTH)) u_miss_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_icache_controller.sv
// Bench for icache_controller: behavioural datapath and L2 around the DUT,
// directed vectors, reset/drop sequences and randomized requests.
module tb_icache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_req_valid;
  logic        pipe_req_fulfilled;
  logic        l2_req_valid;
  logic        l2_req_fulfilled = 1'b0;
  logic        valid_block_match;
  logic        counter_done;
  logic        load_mode;
  logic        perform_write;
  logic        clear_selected_valid_bit;
  logic        finish_new_line_install;
  logic        set_new_l2_block_address;
  logic        reset_counter;
  logic        decrement_counter;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_controller #(.STAT_WIDTH(32)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .pipe_req_valid           (pipe_req_valid),
    .pipe_req_fulfilled       (pipe_req_fulfilled),
    .l2_req_valid             (l2_req_valid),
    .l2_req_fulfilled         (l2_req_fulfilled),
    .valid_block_match        (valid_block_match),
    .counter_done             (counter_done),
    .load_mode                (load_mode),
    .perform_write            (perform_write),
    .clear_selected_valid_bit (clear_selected_valid_bit),
    .finish_new_line_install  (finish_new_line_install),
    .set_new_l2_block_address (set_new_l2_block_address),
    .reset_counter            (reset_counter),
    .decrement_counter        (decrement_counter),
    .hit_count                (hit_count),
    .miss_count               (miss_count)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // L2 contents: a fixed scramble of the word address
  function automatic logic [31:0] l2_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Datapath model: 32 sets of 8-word lines, tag = addr[31:10]
  logic        dp_clear;
  logic        dp_valid [32];
  logic [21:0] dp_tag   [32];
  logic [31:0] dp_data  [32][8];
  logic [26:0] l2_blk;
  logic [2:0]  fill_cnt;
  logic [31:0] pipe_addr;

  assign valid_block_match = dp_valid[pipe_addr[9:5]] && (dp_tag[pipe_addr[9:5]] == pipe_addr[31:10]);
  assign counter_done      = (fill_cnt == 3'd0);

  always @(posedge clk) begin
    if (dp_clear) begin
      for (int s = 0; s < 32; s++) dp_valid[s] <= 1'b0;
      fill_cnt <= 3'd0;
    end else begin
      if (clear_selected_valid_bit) dp_valid[pipe_addr[9:5]] <= 1'b0;
      if (set_new_l2_block_address) l2_blk <= pipe_addr[31:5];
      if (reset_counter) fill_cnt <= 3'd7;
      else if (decrement_counter) fill_cnt <= fill_cnt - 3'd1;
      if (perform_write) dp_data[l2_blk[4:0]][fill_cnt] <= l2_word({l2_blk, fill_cnt, 2'b00});
      if (finish_new_line_install) begin
        dp_valid[l2_blk[4:0]] <= 1'b1;
        dp_tag[l2_blk[4:0]]   <= l2_blk[26:5];
      end
    end
  end

  // L2 responder: answers after stall_cfg idle cycles; optional stray pulses while idle
  int stall_cfg   = 0;
  int stall_cnt   = 0;
  bit spurious_en = 1'b0;

  always @(negedge clk) begin
    if (l2_req_valid) begin
      if (stall_cnt >= stall_cfg) begin
        l2_req_fulfilled = 1'b1;
        stall_cnt = 0;
      end else begin
        l2_req_fulfilled = 1'b0;
        stall_cnt++;
      end
    end else begin
      stall_cnt = 0;
      l2_req_fulfilled = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Per-cycle monitor: records fill order and checks exclusivity rules
  logic [4:0] write_q[$];
  bit         install_seen;

  always @(negedge clk) begin
    #3;
    if (!reset) begin
      if (perform_write) write_q.push_back({fill_cnt, 2'b00});
      if (finish_new_line_install) install_seen = 1'b1;
      checkOutput("write_and_install", 64'(perform_write & finish_new_line_install), 64'd0);
      checkOutput("clear_and_install", 64'(clear_selected_valid_bit & finish_new_line_install), 64'd0);
      checkOutput("fulfil_outside_idle", 64'(pipe_req_fulfilled & (l2_req_valid | finish_new_line_install)), 64'd0);
      checkOutput("write_without_l2", 64'(perform_write & ~(l2_req_valid & l2_req_fulfilled)), 64'd0);
      checkOutput("fulfil_without_req", 64'(pipe_req_fulfilled & ~pipe_req_valid), 64'd0);
    end
  end

  // Reference model: which line each set holds, and the expected statistics
  int unsigned exp_hits   = 0;
  int unsigned exp_misses = 0;
  logic [21:0] resident[int];

  function automatic bit model_access(input logic [31:0] a);
    int s = int'(a[9:5]);
    if (resident.exists(s) && resident[s] == a[31:10]) begin
      exp_hits++;
      return 1'b1;
    end
    resident[s] = a[31:10];
    exp_misses++;
    return 1'b0;
  endfunction

  // Drive one request and hold it until fulfilled (bounded)
  task automatic applyStimulus(input logic [31:0] addr, input int stall, output int latency,
                               output logic [31:0] word, output logic [2:0] ctrl0, output logic l2_0);
    @(negedge clk);
    stall_cfg      = stall;
    pipe_addr      = addr;
    pipe_req_valid = 1'b1;
    write_q.delete();
    install_seen   = 1'b0;
    latency        = 0;
    word           = 32'h0;
    #1;
    ctrl0 = {clear_selected_valid_bit, set_new_l2_block_address, reset_counter};
    l2_0  = l2_req_valid;
    while (!pipe_req_fulfilled && latency < 400) begin
      @(negedge clk);
      latency++;
      #1;
    end
    if (pipe_req_fulfilled) word = dp_data[addr[9:5]][addr[4:2]];
    else checkOutput("request_timeout", 64'(latency), 64'd0);
    @(negedge clk);
    pipe_req_valid = 1'b0;
    #1;
  endtask

  task automatic runRequest(input logic [31:0] addr, input int stall, input bit exp_hit, input int exp_lat);
    int          lat;
    logic [31:0] word;
    logic [2:0]  ctrl0;
    logic        l2_0;
    applyStimulus(addr, stall, lat, word, ctrl0, l2_0);
    checkOutput("latency", 64'(lat), 64'(exp_lat));
    checkOutput("miss_ctrl_cycle0", 64'(ctrl0), exp_hit ? 64'd0 : 64'd7);
    checkOutput("l2_valid_cycle0", 64'(l2_0), 64'd0);
    checkOutput("write_count", 64'(write_q.size()), exp_hit ? 64'd0 : 64'd8);
    if (!exp_hit && write_q.size() == 8)
      for (int i = 0; i < 8; i++) checkOutput("fill_order", 64'(write_q[i]), 64'(28 - 4 * i));
    checkOutput("fetched_word", 64'(word), 64'(l2_word({addr[31:2], 2'b00})));
    checkOutput("hit_count", 64'(hit_count), 64'(exp_hits));
    checkOutput("miss_count", 64'(miss_count), 64'(exp_misses));
  endtask

  typedef struct {
    logic [31:0] addr;
    int          stall;
    bit          exp_hit;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] a;
    int          stall;
    bit          h;
    int          guard;

    vecs[0] = '{32'h0000_0000, 0, 1'b0, 10};
    vecs[1] = '{32'h0000_0000, 0, 1'b1, 0};
    vecs[2] = '{32'h0000_1044, 3, 1'b0, 34};
    vecs[3] = '{32'h0000_0400, 0, 1'b0, 10};
    vecs[4] = '{32'h0000_0000, 0, 1'b0, 10};
    vecs[5] = '{32'h0000_105C, 1, 1'b1, 0};
    vecs[6] = '{32'h0000_0404, 0, 1'b0, 10};

    reset          = 1'b1;
    dp_clear       = 1'b1;
    pipe_req_valid = 1'b0;
    pipe_addr      = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_hit_count", 64'(hit_count), 64'd0);
    checkOutput("reset_miss_count", 64'(miss_count), 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    dp_clear = 1'b0;
    #1;
    checkOutput("reset_outputs", 64'({pipe_req_fulfilled, l2_req_valid, load_mode, perform_write,
                clear_selected_valid_bit, finish_new_line_install, set_new_l2_block_address,
                reset_counter, decrement_counter}), 64'd0);

    // Directed vectors: cold miss, hit, stalled miss, conflicts
    for (int i = 0; i < 7; i++) begin
      void'(model_access(vecs[i].addr));
      runRequest(vecs[i].addr, vecs[i].stall, vecs[i].exp_hit, vecs[i].exp_lat);
    end

    // Reset in the middle of a refill
    a = 32'h0000_3080;
    void'(model_access(a));
    @(negedge clk);
    pipe_addr      = a;
    stall_cfg      = 0;
    pipe_req_valid = 1'b1;
    write_q.delete();
    guard = 0;
    while (write_q.size() < 4 && guard < 50) begin
      @(negedge clk);
      #4;
      guard++;
    end
    checkOutput("reset_test_reached_word4", 64'(write_q.size()), 64'd4);
    reset          = 1'b1;
    pipe_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_outputs", 64'({pipe_req_fulfilled, l2_req_valid, load_mode, perform_write,
                clear_selected_valid_bit, finish_new_line_install, set_new_l2_block_address,
                reset_counter, decrement_counter}), 64'd0);
    checkOutput("post_reset_hits", 64'(hit_count), 64'd0);
    checkOutput("post_reset_misses", 64'(miss_count), 64'd0);
    exp_hits   = 0;
    exp_misses = 0;
    resident.delete(int'(a[9:5]));
    @(negedge clk);
    #1;
    checkOutput("post_reset_idle", 64'(l2_req_valid), 64'd0);
    void'(model_access(a));
    runRequest(a, 0, 1'b0, 10);

    // Request withdrawn mid-refill: the line still installs, later access hits
    a = 32'h0000_2060;
    void'(model_access(a));
    @(negedge clk);
    pipe_addr      = a;
    stall_cfg      = 1;
    pipe_req_valid = 1'b1;
    write_q.delete();
    install_seen   = 1'b0;
    repeat (4) @(negedge clk);
    pipe_req_valid = 1'b0;
    guard = 0;
    while (!install_seen && guard < 100) begin
      @(negedge clk);
      #4;
      guard++;
    end
    checkOutput("drop_install_seen", 64'(install_seen), 64'd1);
    checkOutput("drop_write_count", 64'(write_q.size()), 64'd8);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("drop_miss_count", 64'(miss_count), 64'(exp_misses));
    h = model_access(a + 32'd4);
    runRequest(a + 32'd4, 0, h, 0);

    // Randomized traffic over a small address pool to force conflicts
    spurious_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      stall = int'($urandom_range(0, 2));
      h = model_access(a);
      runRequest(a, stall, h, h ? 0 : 2 + 8 * (stall + 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    spurious_en = 1'b0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
